// File: rtl/heichips25_usb_in_arbiter.sv
// ----------------------------------------------------------------------------
// heichips25_usb_in_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the single USB CDC IN byte stream among
//   NUM_REQ on-chip byte producers. Each grant is a bounded burst of at most
//   MAX_BURST bytes (the bulk IN max packet size), so no source can starve
//   the others. Re-arbitration always passes through one IDLE cycle.
//
// Optional feature (macro USB_ARB_HDR_EN):
//   Each burst is preceded by a one-byte channel tag 8'hA0 | grant index so
//   host software can demultiplex sources. The payload limit drops to
//   MAX_BURST-1 so tag plus payload still fits one packet. With the macro
//   enabled MAX_BURST must be at least 2.
//
// Ports:
//   clk           CDC core clock
//   rst           asynchronous active-high reset
//   configured_i  CDC core configured; gates all arbitration and transfers
//   req_valid_i   per-requester byte valid
//   req_data_i    per-requester byte, requester k on [8k+7:8k]
//   req_ready_o   per-requester accept (only the owner can see ready)
//   in_data_o     byte to the CDC IN path
//   in_valid_o    byte valid to the CDC IN path
//   in_ready_i    CDC IN path ready
//   grant_o       one-hot current owner, zero while idle
//   busy_o        high whenever the FSM is not in IDLE
//
// Handshake: a byte moves on any cycle where valid && ready are both high;
// a producer holds data stable and keeps valid high until accepted.
// ----------------------------------------------------------------------------
module heichips25_usb_in_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   configured_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             in_data_o,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
`ifdef USB_ARB_HDR_EN
    localparam int LIMIT = MAX_BURST - 1;
`else
    localparam int LIMIT = MAX_BURST;
`endif
    // Count value at which the next transfer reaches the payload limit.
    localparam logic [CW-1:0] LAST_CNT = CW'(LIMIT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef USB_ARB_HDR_EN
        S_HDR   = 2'd1,
`endif
        S_BURST = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_last;     // last (and current) grant index
    logic [CW-1:0]   r_cnt;      // payload bytes moved in this burst

    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_cand;
    logic [NUM_REQ-1:0] w_onehot;
    logic [7:0]      w_gdata;
    logic            w_gvalid;
    logic            w_xfer;
    logic            w_grant_now;

    // Round-robin search upward from last+1, wrapping; first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_cand  = r_last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IW'((int'(r_last) + i) % NUM_REQ);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Owner's byte and valid, selected by the registered grant index.
    always_comb begin
        w_gdata = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IW'(k) == r_last) begin
                w_gdata = req_data_i[8*k +: 8];
            end
        end
        w_gvalid = req_valid_i[r_last];
        w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_last;
    end

    assign w_grant_now = (r_state == S_IDLE) && configured_i && w_found;

    // Next state and outputs. configured_i low suppresses every transfer in
    // the same cycle and sends the FSM back to IDLE on the next edge.
    always_comb begin
        w_state_nxt = r_state;
        in_valid_o  = 1'b0;
        in_data_o   = 8'h00;
        req_ready_o = '0;
        grant_o     = '0;
        busy_o      = (r_state != S_IDLE);
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_now) begin
`ifdef USB_ARB_HDR_EN
                    w_state_nxt = S_HDR;
`else
                    w_state_nxt = S_BURST;
`endif
                end
            end
`ifdef USB_ARB_HDR_EN
            S_HDR: begin
                grant_o    = w_onehot;
                in_valid_o = configured_i;
                in_data_o  = 8'hA0 | 8'(r_last);
                if (!configured_i) begin
                    w_state_nxt = S_IDLE;
                end else if (in_ready_i) begin
                    w_state_nxt = S_BURST;
                end
            end
`endif
            S_BURST: begin
                grant_o     = w_onehot;
                in_data_o   = w_gdata;
                in_valid_o  = configured_i && w_gvalid;
                req_ready_o = w_onehot & {NUM_REQ{configured_i && in_ready_i}};
                w_xfer      = configured_i && w_gvalid && in_ready_i;
                // A valid gap ends the burst early, even with zero bytes sent.
                if (!configured_i || !w_gvalid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer && (r_cnt == LAST_CNT)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_now) begin
                r_last <= w_sel;
                r_cnt  <= '0;
            end else if (w_xfer) begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule
